mvm_axis_loader: RTL and testbench

//  Upstream feeder for the rtl_mvm tile. Turns host load commands plus a raw data-word stream into

---
 rtl/mvm_axis_loader_if.sv | 29 ++
 rtl/mvm_axis_loader.sv | 145 ++++++++++++++
 tb/tb_mvm_axis_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_axis_loader_if.sv
// AXI-Stream bundle used on the loader's transmit side toward the MVM tile's rx port.
// The master drives payload and tvalid; the slave returns tready.
interface mvm_axis_loader_if #(
   parameter int DATAW = 512,
   parameter int BYTEW = 8,
   parameter int IDW   = 32,
   parameter int DESTW = 12,
   parameter int USERW = 75
) ();
   logic             tvalid;
   logic [DATAW-1:0] tdata;
   logic [BYTEW-1:0] tstrb;
   logic [BYTEW-1:0] tkeep;
   logic [IDW-1:0]   tid;
   logic [DESTW-1:0] tdest;
   logic [USERW-1:0] tuser;
   logic             tlast;
   logic             tready;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
      output tready
   );
endinterface

// File: rtl/mvm_axis_loader.sv
// Turns host load commands plus a raw word stream into single-beat AXIS packets for the MVM tile,
// encoding tuser as {dpe one-hot, op, rf_addr} and sweeping the DPE select for RF writes.
module mvm_axis_loader #(
   parameter int DATAW   = 512,
   parameter int BYTEW   = 8,
   parameter int IDW     = 32,
   parameter int DESTW   = 12,
   parameter int USERW   = 75,
   parameter int DPES    = 64,
   parameter int RFADDRW = 9,
   parameter int CNTW    = 7,
   parameter int TX_DEST = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [RFADDRW-1:0]        cmd_rf_addr,
   input  logic [$clog2(DPES)-1:0]   cmd_dpe_start,
   input  logic [CNTW-1:0]           cmd_count,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATAW-1:0]          in_data,
   mvm_axis_loader_if.master         axis_tx,
   output logic                      busy,
   output logic                      done
);
   localparam int DPEW = $clog2(DPES);

   if (USERW != RFADDRW + 2 + DPES) begin : g_bad_userw
      $error("USERW must equal RFADDRW+2+DPES");
   end

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          op_q;
   logic [RFADDRW-1:0]  addr_q;
   logic [DPEW-1:0]     dpe_q;
   logic [CNTW-1:0]     beats_left;
   logic                vld_p1;
   logic [DATAW-1:0]    tdata_p1;
   logic [USERW-1:0]    tuser_p1;
   logic                done_q;
   logic                cmd_hs;
   logic                in_hs;
   logic                tx_hs;

   function automatic logic [DPES-1:0] dpe_onehot(input logic [DPEW-1:0] idx, input logic en);
      logic [DPES-1:0] oh;
      oh = '0;
      if (en) oh[idx] = 1'b1;
      return oh;
   endfunction

   // Explicit wrap so non-power-of-two DPES counts still roll over at DPES-1.
   function automatic logic [DPEW-1:0] next_dpe(input logic [DPEW-1:0] idx);
      if (idx == DPEW'(DPES - 1)) return '0;
      return idx + DPEW'(1);
   endfunction

   assign cmd_hs = cmd_valid && cmd_ready;
   assign in_hs  = in_valid && in_ready;
   assign tx_hs  = vld_p1 && axis_tx.tready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = rst;
            if (cmd_valid && rst)
               state_nxt = (cmd_op == 2'd3 && cmd_count == '0) ? S_DONE : S_STREAM;
         end
         S_STREAM: begin
            // Single-entry output register: accept whenever it is empty or draining this cycle.
            in_ready = !vld_p1 || axis_tx.tready;
            if (in_valid && (!vld_p1 || axis_tx.tready) && beats_left == CNTW'(1))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (vld_p1 && axis_tx.tready) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Command latch and beat sequencing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= '0;
         addr_q     <= '0;
         dpe_q      <= '0;
         beats_left <= '0;
      end else if (cmd_hs) begin
         op_q       <= cmd_op;
         addr_q     <= (cmd_op == 2'd3) ? cmd_rf_addr : '0;
         dpe_q      <= cmd_dpe_start;
         beats_left <= (cmd_op == 2'd3) ? cmd_count : CNTW'(1);
      end else if (in_hs) begin
         dpe_q      <= next_dpe(dpe_q);
         beats_left <= beats_left - CNTW'(1);
      end
   end

   // Output register stage (p1): loads on input handshake, clears only after a tx handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1   <= 1'b0;
         tdata_p1 <= '0;
         tuser_p1 <= '0;
      end else if (in_hs) begin
         vld_p1   <= 1'b1;
         tdata_p1 <= in_data;
         tuser_p1 <= {dpe_onehot(dpe_q, op_q == 2'd3), op_q, addr_q};
      end else if (tx_hs) begin
         vld_p1   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) done_q <= 1'b0;
      else      done_q <= (state == S_DONE);
   end

   assign busy           = (state != S_IDLE);
   assign done           = done_q;
   assign axis_tx.tvalid = vld_p1;
   assign axis_tx.tdata  = tdata_p1;
   assign axis_tx.tuser  = tuser_p1;
   assign axis_tx.tlast  = vld_p1;
   assign axis_tx.tstrb  = '1;
   assign axis_tx.tkeep  = '1;
   assign axis_tx.tid    = '0;
   assign axis_tx.tdest  = DESTW'(TX_DEST);
endmodule

// File: tb/tb_mvm_axis_loader.sv
// Directed bench for mvm_axis_loader: table of commands with expected beat streams,
// plus hand sequences for zero-count and mid-command reset.
module tb_mvm_axis_loader;
   localparam int DATAW = 512, BYTEW = 8, IDW = 32, DESTW = 12, USERW = 75;
   localparam int DPES = 64, RFADDRW = 9, CNTW = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [8:0]        cmd_rf_addr = '0;
   logic [5:0]        cmd_dpe_start = '0;
   logic [6:0]        cmd_count = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATAW-1:0]  in_data = '0;
   logic              busy;
   logic              done;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int beats_at_done = -1;
   int cyc_cnt = 0;
   int ready_mode = 0;
   logic [3:0] pat = 4'b1001;
   logic [DATAW-1:0] beat_data[$];
   logic [USERW-1:0] beat_user[$];
   logic             prev_stall = 1'b0;
   logic [DATAW-1:0] prev_data;
   logic [USERW-1:0] prev_user;

   always #5 clk = ~clk;

   mvm_axis_loader_if #(.DATAW(DATAW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) axis_tx ();

   mvm_axis_loader #(
      .DATAW(DATAW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW),
      .DPES(DPES), .RFADDRW(RFADDRW), .CNTW(CNTW), .TX_DEST(0)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rf_addr(cmd_rf_addr), .cmd_dpe_start(cmd_dpe_start), .cmd_count(cmd_count),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .axis_tx(axis_tx), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive tready for the coming edge, then observe what that edge will do.
   always @(negedge clk) begin
      cyc_cnt++;
      axis_tx.tready = (ready_mode == 0) ? 1'b1 : pat[cyc_cnt % 4];
      #1;
      if (rst) begin
         if (prev_stall) begin
            chk("hold_tvalid", DATAW'(axis_tx.tvalid), DATAW'(1));
            chk("hold_tdata", axis_tx.tdata, prev_data);
            chk("hold_tuser", DATAW'(axis_tx.tuser), DATAW'(prev_user));
         end
         if (axis_tx.tvalid) chk("tlast", DATAW'(axis_tx.tlast), DATAW'(1));
         if (axis_tx.tvalid && axis_tx.tready) begin
            beat_data.push_back(axis_tx.tdata);
            beat_user.push_back(axis_tx.tuser);
         end
         if (done) begin
            done_cnt++;
            beats_at_done = beat_data.size();
         end
         prev_stall = axis_tx.tvalid && !axis_tx.tready;
         prev_data  = axis_tx.tdata;
         prev_user  = axis_tx.tuser;
      end else begin
         prev_stall = 1'b0;
      end
   end

   typedef struct {
      logic [1:0]       op;
      logic [8:0]       addr;
      logic [5:0]       dpe;
      logic [6:0]       count;
      int               nwords;
      logic [DATAW-1:0] base;
      int               rmode;
      int               exp_beats;
      logic [10:0]      exp_lo;
      int               exp_dpe0;
   } vec_t;

   task automatic send_cmd(input logic [1:0] op, input logic [8:0] addr,
                           input logic [5:0] dpe, input logic [6:0] cnt);
      int n;
      @(negedge clk);
      cmd_op = op; cmd_rf_addr = addr; cmd_dpe_start = dpe; cmd_count = cnt;
      cmd_valid = 1'b1;
      #2;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk); #2; n++;
      end
      if (!cmd_ready) chk("cmd_accept_timeout", DATAW'(cmd_ready), DATAW'(1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drive_words(input int nwords, input logic [DATAW-1:0] base);
      int k, cyc;
      logic hs;
      k = 0; cyc = 0;
      while (k < nwords && cyc < 1000) begin
         @(negedge clk); #2;
         in_valid = 1'b1;
         in_data  = base + DATAW'(k);
         #1 hs = in_ready;
         @(posedge clk);
         if (hs) k++;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (k != nwords) chk("words_accepted", DATAW'(k), DATAW'(nwords));
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int done_before, n;
      logic [DPES-1:0] oh;
      beat_data.delete(); beat_user.delete();
      done_before = done_cnt;
      beats_at_done = -1;
      ready_mode = v.rmode;
      send_cmd(v.op, v.addr, v.dpe, v.count);
      drive_words(v.nwords, v.base);
      n = 0;
      while (done_cnt == done_before && n < 400) begin
         @(negedge clk); #2; n++;
      end
      repeat (3) @(negedge clk);
      #2;
      chk({tag, "_done_pulses"}, DATAW'(done_cnt - done_before), DATAW'(1));
      chk({tag, "_beats_at_done"}, DATAW'(beats_at_done), DATAW'(v.exp_beats));
      chk({tag, "_beat_count"}, DATAW'(beat_data.size()), DATAW'(v.exp_beats));
      for (int k = 0; k < v.exp_beats && k < beat_data.size(); k++) begin
         oh = '0;
         if (v.exp_dpe0 >= 0) oh[(v.exp_dpe0 + k) % DPES] = 1'b1;
         chk($sformatf("%s_data%0d", tag, k), beat_data[k], v.base + DATAW'(k));
         chk($sformatf("%s_user%0d", tag, k), DATAW'(beat_user[k]), DATAW'({oh, v.exp_lo}));
      end
      ready_mode = 0;
   endtask

   initial begin
      vec_t vt[7];
      int   done_before;
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[7];
      int   done_before;
      vt[0] = '{2'd3, 9'h001, 6'd0,  7'd64, 64, '0,            0, 64, 11'h601, 0};
      vt[1] = '{2'd2, 9'h055, 6'd9,  7'd5,  1,  {64{8'h01}},   0, 1,  11'h400, -1};
      vt[2] = '{2'd3, 9'h1A3, 6'd62, 7'd4,  4,  DATAW'(32'hA000), 0, 4, 11'h7A3, 62};
      vt[3] = '{2'd3, 9'h0F0, 6'd10, 7'd8,  8,  DATAW'(32'hB000), 1, 8, 11'h6F0, 10};
      vt[4] = '{2'd1, 9'h007, 6'd3,  7'd0,  1,  DATAW'(32'hC000), 0, 1, 11'h200, -1};
      vt[5] = '{2'd0, 9'h1FF, 6'd5,  7'd100,1,  DATAW'(32'hD000), 1, 1, 11'h000, -1};
      vt[6] = '{2'd3, 9'h0AA, 6'd3,  7'd70, 70, DATAW'(32'hE000), 0, 70, 11'h6AA, 3};

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      chk("rst_tvalid", DATAW'(axis_tx.tvalid), '0);
      chk("rst_tdata", axis_tx.tdata, '0);
      chk("rst_tuser", DATAW'(axis_tx.tuser), '0);
      chk("rst_tlast", DATAW'(axis_tx.tlast), '0);
      chk("rst_busy", DATAW'(busy), '0);
      chk("rst_done", DATAW'(done), '0);
      chk("rst_cmd_ready", DATAW'(cmd_ready), '0);
      chk("rst_in_ready", DATAW'(in_ready), '0);
      rst = 1'b1;
      @(negedge clk); #2;
      chk("idle_cmd_ready", DATAW'(cmd_ready), DATAW'(1));
      chk("tstrb", DATAW'(axis_tx.tstrb), DATAW'(8'hFF));
      chk("tkeep", DATAW'(axis_tx.tkeep), DATAW'(8'hFF));
      chk("tid", DATAW'(axis_tx.tid), '0);
      chk("tdest", DATAW'(axis_tx.tdest), '0);

      for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vt[i]);

      // Zero-count RF write: no beats, busy for one cycle, done two cycles after accept
      beat_data.delete();
      @(negedge clk);
      cmd_op = 2'd3; cmd_rf_addr = 9'h010; cmd_dpe_start = 6'd7; cmd_count = 7'd0;
      cmd_valid = 1'b1;
      #2 chk("z_cmd_ready", DATAW'(cmd_ready), DATAW'(1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk); #2;
      chk("z_busy1", DATAW'(busy), DATAW'(1));
      chk("z_done1", DATAW'(done), '0);
      chk("z_cmd_ready_done", DATAW'(cmd_ready), '0);
      @(negedge clk); #2;
      chk("z_busy2", DATAW'(busy), '0);
      chk("z_done2", DATAW'(done), DATAW'(1));
      @(negedge clk); #2;
      chk("z_done3", DATAW'(done), '0);
      chk("z_beats", DATAW'(beat_data.size()), '0);

      // Reset after 3 of 10 beats: everything clears at once, no done
      done_before = done_cnt;
      send_cmd(2'd3, 9'h033, 6'd20, 7'd10);
      drive_words(3, DATAW'(32'hF000));
      #3 rst = 1'b0;
      #1;
      chk("ar_tvalid", DATAW'(axis_tx.tvalid), '0);
      chk("ar_tdata", axis_tx.tdata, '0);
      chk("ar_tuser", DATAW'(axis_tx.tuser), '0);
      chk("ar_tlast", DATAW'(axis_tx.tlast), '0);
      chk("ar_busy", DATAW'(busy), '0);
      chk("ar_done", DATAW'(done), '0);
      chk("ar_cmd_ready", DATAW'(cmd_ready), '0);
      chk("ar_in_ready", DATAW'(in_ready), '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      chk("ar_no_done", DATAW'(done_cnt - done_before), '0);
      chk("ar_idle_busy", DATAW'(busy), '0);
      run_vec("post_rst", '{2'd3, 9'h002, 6'd40, 7'd3, 3, DATAW'(32'h5000), 0, 3, 11'h602, 40});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
